relu_backward: RTL and testbench

Gradient stage of the ReLU layer: streams forward input x (handle `a`) and upstream gradient dy (handle `b`) from memory and writes dx (handle `d`), passing each dy element where x > 0 and zeroing it otherwise. Sits downstream of the loss/next-layer gradient producer and upstream of the previous layer's backward stage. The block is started by the scheduler with `go`, copies the tensor header, then processes one element per loop iteration over `mem_handle` ports.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/mem_access_ctrl.sv | 74 +++++++
 rtl/relu_backward.sv | 175 +++++++++++++++++
 tb/tb_relu_backward.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpu_pkg
// Purpose : Shared definitions for the ReLU backward stage: the controller
//           state encoding, the IEEE-754 single-precision zero word and a
//           strict-positivity test on a raw float32 word.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package fpu_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [3:0] {
    ST_WAIT    = 4'd0,
    ST_HDR_A   = 4'd1,
    ST_HDR_B   = 4'd2,
    ST_HDR_W   = 4'd3,
    ST_DIM_A   = 4'd4,
    ST_DIM_B   = 4'd5,
    ST_DIM_W   = 4'd6,
    ST_LOOP    = 4'd7,
    ST_LOAD_X  = 4'd8,
    ST_LOAD_DY = 4'd9,
    ST_WRITE   = 4'd10,
    ST_DONE    = 4'd11
  } relu_bw_state_t;

  // Strictly positive: sign clear and magnitude non-zero, so +0, -0 and all
  // negative encodings are rejected.
  function automatic logic fp_is_pos(input logic [31:0] v);
    return (v[31] == 1'b0) && (v[30:0] != 31'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl
// Purpose : One-handle request/acknowledge sequencer. While i_req is high and
//           no access is outstanding it raises avail plus r_en or w_en; on the
//           memory's done cycle it drops them and advances ptr by one.
// Ports   : clk, rst_l        clock, async active-low reset
//           i_clr             zero the pointer (start of a new tensor pass)
//           i_req, i_wr       access request and direction (1 = write)
//           i_wdata           write data latched when the access is issued
//           i_bump            advance ptr without an access
//           i_mem_done        memory completion strobe
//           o_ack             access completes this cycle
//           o_ptr, o_avail, o_r_en, o_w_en, o_data_store  handle outputs
// Rev     : 1.0  initial release
// ============================================================================
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        i_clr,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  input  logic        i_bump,
  input  logic        i_mem_done,
  output logic        o_ack,
  output logic [31:0] o_ptr,
  output logic        o_avail,
  output logic        o_r_en,
  output logic        o_w_en,
  output logic [31:0] o_data_store
);

  logic [31:0] r_ptr;
  logic        r_avail;
  logic        r_r_en;
  logic        r_w_en;
  logic [31:0] r_data_store;

  assign o_ack = r_avail & i_mem_done;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_ptr        <= 32'd0;
      r_avail      <= 1'b0;
      r_r_en       <= 1'b0;
      r_w_en       <= 1'b0;
      r_data_store <= 32'd0;
    end else if (i_clr) begin
      r_ptr <= 32'd0;
    end else if (o_ack) begin
      r_avail      <= 1'b0;
      r_r_en       <= 1'b0;
      r_w_en       <= 1'b0;
      r_data_store <= 32'd0;
      r_ptr        <= r_ptr + 32'd1;
    end else if (i_req && !r_avail) begin
      r_avail      <= 1'b1;
      r_r_en       <= ~i_wr;
      r_w_en       <= i_wr;
      r_data_store <= i_wr ? i_wdata : 32'd0;
    end else if (i_bump) begin
      r_ptr <= r_ptr + 32'd1;
    end
  end

  assign o_ptr        = r_ptr;
  assign o_avail      = r_avail;
  assign o_r_en       = r_r_en;
  assign o_w_en       = r_w_en;
  assign o_data_store = r_data_store;

endmodule
`default_nettype wire

// File: rtl/relu_backward.sv
`default_nettype none
// ============================================================================
// Module  : relu_backward
// Purpose : ReLU gradient stage. Copies the tensor header of x (handle a) to
//           dx (handle d), skipping the matching header of dy (handle b), then
//           per element writes dx = dy where x > 0, else masks it.
// Config  : RELU_BW_ZERO_WRITE_EN - when defined, masked elements are written
//           as +0.0; otherwise they are skipped and only d.ptr advances.
// Ports   : clk, rst_l      clock, async active-low reset
//           go, done        start request / high while finished
//           pass_cnt        count of elements whose gradient passed
//           {o,i}_<h>_*     memory handles a (x), b (dy), c (unused), d (dx)
// Rev     : 1.0  initial release
// ============================================================================
module relu_backward
  import fpu_pkg::*;
#(
  parameter int MAX_DIMS = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        go,
  output logic        done,
  output logic [31:0] pass_cnt,
  // handle a : x, read-only
  output logic [31:0] o_a_ptr,
  output logic        o_a_avail,
  output logic        o_a_r_en,
  output logic        o_a_w_en,
  output logic [31:0] o_a_data_store,
  input  logic [31:0] i_a_data_load,
  input  logic        i_a_done,
  input  logic [31:0] i_a_region_end,
  // handle b : dy, read-only
  output logic [31:0] o_b_ptr,
  output logic        o_b_avail,
  output logic        o_b_r_en,
  output logic        o_b_w_en,
  output logic [31:0] o_b_data_store,
  input  logic [31:0] i_b_data_load,
  input  logic        i_b_done,
  input  logic [31:0] i_b_region_end,
  // handle c : unused
  output logic [31:0] o_c_ptr,
  output logic        o_c_avail,
  output logic        o_c_r_en,
  output logic        o_c_w_en,
  output logic [31:0] o_c_data_store,
  input  logic [31:0] i_c_data_load,
  input  logic        i_c_done,
  input  logic [31:0] i_c_region_end,
  // handle d : dx, write-only
  output logic [31:0] o_d_ptr,
  output logic        o_d_avail,
  output logic        o_d_r_en,
  output logic        o_d_w_en,
  output logic [31:0] o_d_data_store,
  input  logic [31:0] i_d_data_load,
  input  logic        i_d_done,
  input  logic [31:0] i_d_region_end
);

  relu_bw_state_t r_state, w_next;
  logic [31:0]    r_dims_left;
  logic [31:0]    r_x;
  logic [31:0]    r_wdata;
  logic [31:0]    r_pass_cnt;

  logic w_ack_a, w_ack_b, w_ack_d;
  logic w_start, w_pass;
  logic w_req_a, w_req_b, w_req_d;
  logic w_bump_d;
  logic w_unused;

  assign w_start = (r_state == ST_WAIT) && go;
  assign w_pass  = fp_is_pos(r_x);

  assign w_req_a = (r_state == ST_HDR_A) || (r_state == ST_DIM_A) || (r_state == ST_LOAD_X);
  assign w_req_b = (r_state == ST_HDR_B) || (r_state == ST_DIM_B) || (r_state == ST_LOAD_DY);
  assign w_req_d = (r_state == ST_HDR_W) || (r_state == ST_DIM_W) || (r_state == ST_WRITE);

`ifdef RELU_BW_ZERO_WRITE_EN
  assign w_bump_d = 1'b0;
`else
  // A masked element still owns a dx slot; step over it without writing.
  assign w_bump_d = (r_state == ST_LOAD_DY) && w_ack_b && !w_pass;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT:    if (go)      w_next = ST_HDR_A;
      ST_HDR_A:   if (w_ack_a) w_next = ST_HDR_B;
      ST_HDR_B:   if (w_ack_b) w_next = ST_HDR_W;
      ST_HDR_W:   if (w_ack_d) w_next = (r_dims_left != 32'd0) ? ST_DIM_A : ST_LOOP;
      ST_DIM_A:   if (w_ack_a) w_next = ST_DIM_B;
      ST_DIM_B:   if (w_ack_b) w_next = ST_DIM_W;
      ST_DIM_W:   if (w_ack_d) w_next = (r_dims_left == 32'd1) ? ST_LOOP : ST_DIM_A;
      ST_LOOP:    w_next = (o_d_ptr == i_d_region_end) ? ST_DONE : ST_LOAD_X;
      ST_LOAD_X:  if (w_ack_a) w_next = ST_LOAD_DY;
`ifdef RELU_BW_ZERO_WRITE_EN
      ST_LOAD_DY: if (w_ack_b) w_next = ST_WRITE;
`else
      ST_LOAD_DY: if (w_ack_b) w_next = w_pass ? ST_WRITE : ST_LOOP;
`endif
      ST_WRITE:   if (w_ack_d) w_next = ST_LOOP;
      ST_DONE:    if (!go)     w_next = ST_WAIT;
      default:    w_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= ST_WAIT;
      r_dims_left <= 32'd0;
      r_x         <= 32'd0;
      r_wdata     <= 32'd0;
      r_pass_cnt  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_start) r_pass_cnt <= 32'd0;
      case (r_state)
        ST_HDR_A: if (w_ack_a) begin
          // N is copied verbatim; only the dim-word loop is clamped.
          r_wdata     <= i_a_data_load;
          r_dims_left <= (i_a_data_load > 32'(MAX_DIMS)) ? 32'(MAX_DIMS) : i_a_data_load;
        end
        ST_DIM_A:  if (w_ack_a) r_wdata <= i_a_data_load;
        ST_DIM_W:  if (w_ack_d) r_dims_left <= r_dims_left - 32'd1;
        ST_LOAD_X: if (w_ack_a) r_x <= i_a_data_load;
        ST_LOAD_DY: if (w_ack_b) begin
          r_wdata <= w_pass ? i_b_data_load : FP_ZERO;
          if (w_pass) r_pass_cnt <= r_pass_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

  mem_access_ctrl u_ctrl_a (
    .clk(clk), .rst_l(rst_l), .i_clr(w_start), .i_req(w_req_a), .i_wr(1'b0),
    .i_wdata(FP_ZERO), .i_bump(1'b0), .i_mem_done(i_a_done), .o_ack(w_ack_a),
    .o_ptr(o_a_ptr), .o_avail(o_a_avail), .o_r_en(o_a_r_en), .o_w_en(o_a_w_en),
    .o_data_store(o_a_data_store)
  );

  mem_access_ctrl u_ctrl_b (
    .clk(clk), .rst_l(rst_l), .i_clr(w_start), .i_req(w_req_b), .i_wr(1'b0),
    .i_wdata(FP_ZERO), .i_bump(1'b0), .i_mem_done(i_b_done), .o_ack(w_ack_b),
    .o_ptr(o_b_ptr), .o_avail(o_b_avail), .o_r_en(o_b_r_en), .o_w_en(o_b_w_en),
    .o_data_store(o_b_data_store)
  );

  mem_access_ctrl u_ctrl_d (
    .clk(clk), .rst_l(rst_l), .i_clr(w_start), .i_req(w_req_d), .i_wr(1'b1),
    .i_wdata(r_wdata), .i_bump(w_bump_d), .i_mem_done(i_d_done), .o_ack(w_ack_d),
    .o_ptr(o_d_ptr), .o_avail(o_d_avail), .o_r_en(o_d_r_en), .o_w_en(o_d_w_en),
    .o_data_store(o_d_data_store)
  );

  assign o_c_ptr        = 32'd0;
  assign o_c_avail      = 1'b0;
  assign o_c_r_en       = 1'b0;
  assign o_c_w_en       = 1'b0;
  assign o_c_data_store = 32'd0;

  assign done     = (r_state == ST_DONE);
  assign pass_cnt = r_pass_cnt;

  // Handle inputs with no role in this stage.
  assign w_unused = ^{i_a_region_end, i_b_region_end, i_c_region_end,
                      i_c_data_load, i_c_done, i_d_data_load};

endmodule
`default_nettype wire

// File: tb/tb_relu_backward.sv
`default_nettype none
// ============================================================================
// Module  : tb_relu_backward
// Purpose : Self-checking bench for relu_backward: directed vector table,
//           randomized tensors against a float-sign reference model, random
//           memory latency with a mid-element reset, and go-handling checks.
// Rev     : 1.0  initial release
// ============================================================================
module tb_relu_backward;

`ifdef RELU_BW_ZERO_WRITE_EN
  localparam logic [31:0] MASKED = 32'h0000_0000;
`else
  localparam logic [31:0] MASKED = 32'hDEAD_BEEF;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        go = 1'b0;
  logic        done;
  logic [31:0] pass_cnt;

  logic [31:0] a_ptr, a_store, a_load, a_rend;
  logic        a_avail, a_ren, a_wen, a_done;
  logic [31:0] b_ptr, b_store, b_load, b_rend;
  logic        b_avail, b_ren, b_wen, b_done;
  logic [31:0] c_ptr, c_store, c_load, c_rend;
  logic        c_avail, c_ren, c_wen, c_done;
  logic [31:0] d_ptr, d_store, d_load, d_rend;
  logic        d_avail, d_ren, d_wen, d_done;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] mem_d [64];
  bit          load_d = 1'b0;
  bit          rand_lat = 1'b0;
  int          a_cnt = 0, b_cnt = 0, d_cnt = 0;
  int          a_lat = 1, b_lat = 1, d_lat = 1;
  int          excl_cnt = 0;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  relu_backward #(.MAX_DIMS(2)) dut (
    .clk(clk), .rst_l(rst_l), .go(go), .done(done), .pass_cnt(pass_cnt),
    .o_a_ptr(a_ptr), .o_a_avail(a_avail), .o_a_r_en(a_ren), .o_a_w_en(a_wen),
    .o_a_data_store(a_store), .i_a_data_load(a_load), .i_a_done(a_done), .i_a_region_end(a_rend),
    .o_b_ptr(b_ptr), .o_b_avail(b_avail), .o_b_r_en(b_ren), .o_b_w_en(b_wen),
    .o_b_data_store(b_store), .i_b_data_load(b_load), .i_b_done(b_done), .i_b_region_end(b_rend),
    .o_c_ptr(c_ptr), .o_c_avail(c_avail), .o_c_r_en(c_ren), .o_c_w_en(c_wen),
    .o_c_data_store(c_store), .i_c_data_load(c_load), .i_c_done(c_done), .i_c_region_end(c_rend),
    .o_d_ptr(d_ptr), .o_d_avail(d_avail), .o_d_r_en(d_ren), .o_d_w_en(d_wen),
    .o_d_data_store(d_store), .i_d_data_load(d_load), .i_d_done(d_done), .i_d_region_end(d_rend)
  );

  // ---------------- memory models: done after a_lat cycles of avail -------
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      a_done <= 1'b0; a_cnt <= 0; a_load <= 32'd0;
    end else if (a_avail && a_ren && !a_done) begin
      if (a_cnt + 1 >= a_lat) begin
        a_done <= 1'b1; a_cnt <= 0; a_load <= mem_a[a_ptr[5:0]];
        a_lat  <= rand_lat ? int'($urandom_range(7, 1)) : 1;
      end else a_cnt <= a_cnt + 1;
    end else begin
      a_done <= 1'b0; a_cnt <= 0;
    end
  end

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      b_done <= 1'b0; b_cnt <= 0; b_load <= 32'd0;
    end else if (b_avail && b_ren && !b_done) begin
      if (b_cnt + 1 >= b_lat) begin
        b_done <= 1'b1; b_cnt <= 0; b_load <= mem_b[b_ptr[5:0]];
        b_lat  <= rand_lat ? int'($urandom_range(7, 1)) : 1;
      end else b_cnt <= b_cnt + 1;
    end else begin
      b_done <= 1'b0; b_cnt <= 0;
    end
  end

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      d_done <= 1'b0; d_cnt <= 0;
    end else begin
      if (load_d) for (int i = 0; i < 64; i++) mem_d[i] <= 32'hDEAD_BEEF;
      if (d_avail && d_wen && !d_done) begin
        if (d_cnt + 1 >= d_lat) begin
          d_done <= 1'b1; d_cnt <= 0; mem_d[d_ptr[5:0]] <= d_store;
          d_lat  <= rand_lat ? int'($urandom_range(7, 1)) : 1;
        end else d_cnt <= d_cnt + 1;
      end else begin
        d_done <= 1'b0; d_cnt <= 0;
      end
    end
  end

  // At most one handle active per cycle; handle c must stay idle.
  always @(negedge clk) begin
    if (rst_l) begin
      if ((int'(a_avail) + int'(b_avail) + int'(c_avail) + int'(d_avail)) > 1 ||
          c_ptr != 32'd0 || c_avail || c_ren || c_wen || c_store != 32'd0 ||
          a_wen || b_wen || d_ren)
        excl_cnt <= excl_cnt + 1;
    end
  end

  // ---------------- checking helpers --------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
    end
  endtask

  typedef logic [5:0][31:0] elem_t;

  // Runs one tensor. do_reset aborts it with rst_l while a dy element is
  // being loaded; max_cyc > 0 bounds the start-to-done latency.
  task automatic run_case(input string name, input int ndim, input logic [31:0] d0,
                          input logic [31:0] d1, input int nel, input elem_t x,
                          input elem_t dy, input elem_t dx, input int exp_pass,
                          input bit do_reset, input int max_cyc);
    int base, rend, cyc;
    bit ok, seen;
    logic [31:0] expw [16];
    base = 1 + ((ndim > 2) ? 2 : ndim);
    rend = base + nel;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h0BAD_0000 + i;
      mem_b[i] = 32'h0BAD_1000 + i;
    end
    mem_a[0] = ndim;  mem_b[0] = 32'h5A5A_5A5A;
    mem_a[1] = d0;    mem_b[1] = ~d0;
    mem_a[2] = d1;    mem_b[2] = ~d1;
    expw[0] = ndim; expw[1] = d0; expw[2] = d1;
    for (int j = 0; j < nel; j++) begin
      mem_a[base + j] = x[j];
      mem_b[base + j] = dy[j];
      expw[base + j]  = dx[j];
    end
    a_rend = rend; b_rend = rend; d_rend = rend;
    load_d = 1'b1;
    @(negedge clk);
    load_d = 1'b0;
    go = 1'b1;

    if (do_reset) begin
      seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (b_avail && b_ptr >= base) begin seen = 1'b1; break; end
      end
      check({name, " reached LOAD_DY"}, 32'(seen), 32'd1);
      rst_l = 1'b0;
      #1;
      check({name, " rst ptrs"}, a_ptr | b_ptr | c_ptr | d_ptr, 32'd0);
      check({name, " rst stores"}, a_store | b_store | c_store | d_store, 32'd0);
      check({name, " rst enables"},
            32'({a_avail, a_ren, a_wen, b_avail, b_ren, b_wen,
                 c_avail, c_ren, c_wen, d_avail, d_ren, d_wen}), 32'd0);
      check({name, " rst done/pass_cnt"}, pass_cnt | 32'(done), 32'd0);
      go = 1'b0;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      repeat (3) @(negedge clk);
      check({name, " idle after reset"}, 32'({done, a_avail, b_avail, d_avail}), 32'd0);
      return;
    end

    wait_done(ok, cyc);
    check({name, " done reached"}, 32'(ok), 32'd1);
    if (max_cyc > 0) check({name, " done latency bound"}, 32'(cyc <= max_cyc), 32'd1);
    check({name, " pass_cnt"}, pass_cnt, 32'(exp_pass));
    check({name, " d.ptr at region_end"}, d_ptr, 32'(rend));
    check({name, " a reads"}, a_ptr, 32'(rend));
    check({name, " b reads"}, b_ptr, 32'(rend));
    for (int i = 0; i < rend; i++)
      check($sformatf("%s d[%0d]", name, i), mem_d[i], expw[i]);
    check({name, " d past region untouched"}, mem_d[rend], 32'hDEAD_BEEF);
    // go still high: must stay in DONE without restarting.
    repeat (3) @(negedge clk);
    check({name, " held in DONE"}, 32'({done, a_avail}), 32'b10);
    check({name, " pass_cnt held"}, pass_cnt, 32'(exp_pass));
    go = 1'b0;
    @(negedge clk);
    check({name, " done drops"}, 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check({name, " no restart"}, 32'({done, a_avail}), 32'd0);
  endtask

  typedef struct {
    string       name;
    int          ndim;
    logic [31:0] d0, d1;
    int          nel;
    elem_t       x, dy, dx;
    int          pass;
    int          max_cyc;
  } vec_t;

  vec_t vt [4];

  // Random element pool biased toward the sign/zero boundaries.
  function automatic logic [31:0] rand_x();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(4, 0))
      0: v = 32'h0000_0000;
      1: v = 32'h8000_0000;
      2: v[31] = 1'b1;
      3: v = 32'h0000_0001;
      default: v[31] = 1'b0;
    endcase
    return v;
  endfunction

  task automatic run_random(input string name, input bit do_reset, input bit force_nonempty);
    int ndim, nel, exp_pass;
    logic [31:0] d0, d1;
    elem_t x, dy, dx;
    ndim = $urandom_range(2, 1);
    if (ndim == 1) begin
      d0 = $urandom_range(6, force_nonempty ? 1 : 0);
      d1 = 32'd0;
      nel = d0;
    end else begin
      d0 = $urandom_range(2, force_nonempty ? 1 : 0);
      d1 = $urandom_range(2, force_nonempty ? 1 : 0);
      nel = d0 * d1;
    end
    x = '0; dy = '0; dx = '0;
    exp_pass = 0;
    for (int j = 0; j < nel; j++) begin
      x[j]  = rand_x();
      dy[j] = $urandom;
      // Positive float <=> positive when read as a signed integer.
      if ($signed(x[j]) > 0) begin
        dx[j] = dy[j];
        exp_pass++;
      end else begin
        dx[j] = MASKED;
      end
    end
    run_case(name, ndim, d0, d1, nel, x, dy, dx, exp_pass, do_reset, 0);
    if (do_reset)
      run_case({name, " rerun"}, ndim, d0, d1, nel, x, dy, dx, exp_pass, 1'b0, 0);
  endtask

  initial begin
    c_load = 32'd0; c_done = 1'b0; c_rend = 32'd0;
    a_rend = 32'd0; b_rend = 32'd0; d_rend = 32'd0;

    vt[0] = '{"t1 relu 1d", 1, 32'd4, 32'd0, 4,
              {64'h0, 32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'h4000_0000},
              {64'h0, 32'h40E0_0000, 32'h40A0_0000, 32'h4040_0000, 32'h3F80_0000},
              {64'h0, MASKED, MASKED, MASKED, 32'h3F80_0000}, 1, 0};
    vt[1] = '{"t2 relu 2d", 2, 32'd2, 32'd3, 6,
              {32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000},
              {32'h40C0_0000, 32'h40A0_0000, 32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000},
              {32'h40C0_0000, 32'h40A0_0000, 32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000},
              6, 0};
    vt[2] = '{"t3 denorm/inf/neg", 1, 32'd3, 32'd0, 3,
              {96'h0, 32'h7F80_0000, 32'hFFFF_FFFF, 32'h0000_0001},
              {96'h0, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
              {96'h0, 32'h3333_3333, MASKED, 32'h1111_1111}, 2, 0};
    vt[3] = '{"t4 zero elems", 1, 32'd0, 32'd0, 0, '0, '0, '0, 0, 20};

    repeat (3) @(negedge clk);
    check("reset done", 32'(done), 32'd0);
    check("reset pass_cnt", pass_cnt, 32'd0);
    check("reset d handle", d_ptr | d_store | 32'({d_avail, d_wen}), 32'd0);
    rst_l = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_case(vt[i].name, vt[i].ndim, vt[i].d0, vt[i].d1, vt[i].nel,
               vt[i].x, vt[i].dy, vt[i].dx, vt[i].pass, 1'b0, vt[i].max_cyc);

    for (int r = 0; r < 6; r++)
      run_random($sformatf("rand%0d", r), 1'b0, 1'b0);

    rand_lat = 1'b1;
    for (int r = 0; r < 6; r++)
      run_random($sformatf("randlat%0d", r), 1'b0, 1'b0);
    run_random("rst mid LOAD_DY", 1'b1, 1'b1);
    run_case(vt[1].name, vt[1].ndim, vt[1].d0, vt[1].d1, vt[1].nel,
             vt[1].x, vt[1].dy, vt[1].dx, vt[1].pass, 1'b0, 0);

    check("handle exclusivity / c idle", 32'(excl_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
